// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module : pipeline_pkg
// Brief  : Shared pipeline types, ALUOp encodings and opcode constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_JMP    = 2'b11;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic [1:0] ALUOp;
        logic       memWrite;
        logic       ALUSrc;
        logic       regWrite;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // ALUSrc is not a side-effecting control, so it survives a bubble.
    function automatic ctrl_t kill_ctrl(input ctrl_t c);
        ctrl_t k;
        k        = BUBBLE_CTRL;
        k.ALUSrc = c.ALUSrc;
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_reg_hazard_detect.sv
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use hazard detector (ID vs. EX).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_ALUSrc,
    input  logic             id_memWrite,
    input  logic             ex_valid,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hz
);

    logic use_rs2;
    logic rs1_hit;
    logic rs2_hit;

    // rs1 is always compared, which is conservative for J-type.
    assign use_rs2 = ~id_ALUSrc | id_memWrite;
    assign rs1_hit = (id_rs1 == ex_rd);
    assign rs2_hit = use_rs2 & (id_rs2 == ex_rd);

    assign hz = id_valid & ex_valid & ex_memRead & (ex_rd != '0) & (rs1_hit | rs2_hit);

endmodule

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ============================================================================
// Module : id_ex_reg
// Brief  : ID/EX pipeline register with load-use bubble, stall and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_5,
    input  logic             id_branch,
    input  logic             id_memRead,
    input  logic             id_memToReg,
    input  logic             id_memWrite,
    input  logic             id_ALUSrc,
    input  logic             id_regWrite,
    input  logic [1:0]       id_ALUOp,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_5,
    output logic             ex_branch,
    output logic             ex_memRead,
    output logic             ex_memToReg,
    output logic             ex_memWrite,
    output logic             ex_ALUSrc,
    output logic             ex_regWrite,
    output logic [1:0]       ex_ALUOp,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hz;

    assign id_ctrl = {id_branch, id_memRead, id_memToReg, id_ALUOp,
                      id_memWrite, id_ALUSrc, id_regWrite};

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_ALUSrc   (id_ALUSrc),
        .id_memWrite (id_memWrite),
        .ex_valid    (ex_valid),
        .ex_memRead  (ex_ctrl.memRead),
        .ex_rd       (ex_rd),
        .hz          (hz)
    );

    // A flush kills the ID instruction, so it also cancels the hazard hold.
    assign load_use_stall = hz & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= BUBBLE_CTRL;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            ex_funct7_5  <= 1'b0;
            bubble_count <= '0;
        end else if (flush || !stall) begin
            // Data and index fields always follow ID, even into a bubble.
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7_5 <= id_funct7_5;
            if (flush || hz || !id_valid) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= kill_ctrl(id_ctrl);
            end else begin
                ex_valid <= 1'b1;
                ex_ctrl  <= id_ctrl;
            end
            if (!flush && hz && (bubble_count != {CNT_W{1'b1}})) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

    assign ex_branch   = ex_ctrl.branch;
    assign ex_memRead  = ex_ctrl.memRead;
    assign ex_memToReg = ex_ctrl.memToReg;
    assign ex_ALUOp    = ex_ctrl.ALUOp;
    assign ex_memWrite = ex_ctrl.memWrite;
    assign ex_ALUSrc   = ex_ctrl.ALUSrc;
    assign ex_regWrite = ex_ctrl.regWrite;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// Module : tb_id_ex_reg
// Brief  : Scoreboard bench for id_ex_reg against an instruction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_reg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1d;
        logic [XLEN-1:0]  rs2d;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [2:0]       f3;
        logic             f75;
        logic             branch;
        logic             memRead;
        logic             memToReg;
        logic [1:0]       aluop;
        logic             memWrite;
        logic             aluSrc;
        logic             regWrite;
    } instr_t;

    typedef struct packed {
        logic   rst;
        logic   stall;
        logic   flush;
        instr_t i;
    } stim_t;

    typedef struct packed {
        logic             lus;
        instr_t           ex;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, stall, flush;
    instr_t id;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7_5, ex_branch, ex_memRead, ex_memToReg;
    logic             ex_memWrite, ex_ALUSrc, ex_regWrite;
    logic [1:0]       ex_ALUOp;
    logic             load_use_stall;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id.valid), .id_pc(id.pc), .id_rs1_data(id.rs1d),
        .id_rs2_data(id.rs2d), .id_imm(id.imm), .id_rs1(id.rs1),
        .id_rs2(id.rs2), .id_rd(id.rd), .id_funct3(id.f3),
        .id_funct7_5(id.f75), .id_branch(id.branch), .id_memRead(id.memRead),
        .id_memToReg(id.memToReg), .id_memWrite(id.memWrite),
        .id_ALUSrc(id.aluSrc), .id_regWrite(id.regWrite), .id_ALUOp(id.aluop),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7_5(ex_funct7_5), .ex_branch(ex_branch),
        .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
        .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_regWrite(ex_regWrite), .ex_ALUOp(ex_ALUOp),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    // Reference model: the instruction sitting in EX and the bubble tally.
    instr_t           m_ex;
    int               m_bubbles;
    exp_t             sb[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_fail   = 0;
    bit               done     = 1'b0;

    function automatic bit reads_reg(instr_t i, logic [REG_W-1:0] r);
        bit needs_rs2 = !i.aluSrc || i.memWrite;
        return (i.rs1 == r) || (needs_rs2 && i.rs2 == r);
    endfunction

    function automatic bit load_use(instr_t idi, instr_t exi);
        return idi.valid && exi.valid && exi.memRead && exi.rd != 0 && reads_reg(idi, exi.rd);
    endfunction

    task automatic step(input stim_t s);
        exp_t   e;
        bit     haz;
        instr_t nx;
        rst = s.rst; stall = s.stall; flush = s.flush; id = s.i;
        haz   = load_use(s.i, m_ex);
        e.lus = !s.rst && !s.flush && haz;
        e.ex  = m_ex;
        e.cnt = CNT_W'(m_bubbles);
        sb.push_back(e);
        if (s.rst) begin
            m_ex      = '0;
            m_bubbles = 0;
        end else if (s.flush || !s.stall) begin
            nx = s.i;
            if (s.flush || haz || !s.i.valid) begin
                nx.valid    = 1'b0;
                nx.branch   = 1'b0;
                nx.memRead  = 1'b0;
                nx.memToReg = 1'b0;
                nx.aluop    = 2'b00;
                nx.memWrite = 1'b0;
                nx.regWrite = 1'b0;
            end
            if (!s.flush && haz && m_bubbles < (1 << CNT_W) - 1) m_bubbles++;
            m_ex = nx;
        end
        @(posedge clk);
        #2;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(7) != 0);
        i.pc       = $urandom;
        i.rs1d     = $urandom;
        i.rs2d     = $urandom;
        i.imm      = $urandom;
        i.rs1      = REG_W'($urandom_range(7));
        i.rs2      = REG_W'($urandom_range(7));
        i.rd       = REG_W'($urandom_range(7));
        i.f3       = 3'($urandom);
        i.f75      = 1'($urandom);
        i.branch   = 1'($urandom);
        i.memRead  = ($urandom_range(2) == 0);
        i.memToReg = 1'($urandom);
        i.aluop    = 2'($urandom);
        i.memWrite = 1'($urandom);
        i.aluSrc   = 1'($urandom);
        i.regWrite = 1'($urandom);
        return i;
    endfunction

    function automatic stim_t mk(input bit r, input bit st, input bit fl, input instr_t i);
        stim_t s;
        s.rst = r; s.stall = st; s.flush = fl; s.i = i;
        return s;
    endfunction

    function automatic instr_t lw(input int rd, input int rs1);
        instr_t i = rand_instr();
        i.valid = 1; i.rd = REG_W'(rd); i.rs1 = REG_W'(rs1);
        {i.branch, i.memRead, i.memToReg, i.memWrite, i.aluSrc, i.regWrite} = 6'b011011;
        i.aluop = 2'b00;
        return i;
    endfunction

    function automatic instr_t rtype(input int rd, input int rs1, input int rs2);
        instr_t i = rand_instr();
        i.valid = 1; i.rd = REG_W'(rd); i.rs1 = REG_W'(rs1); i.rs2 = REG_W'(rs2);
        {i.branch, i.memRead, i.memToReg, i.memWrite, i.aluSrc, i.regWrite} = 6'b000001;
        i.aluop = 2'b10;
        return i;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: the register presents a new EX state every cycle.
    initial begin : monitor
        exp_t   e;
        instr_t a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1,
                      ex_rs2, ex_rd, ex_funct3, ex_funct7_5, ex_branch, ex_memRead,
                      ex_memToReg, ex_ALUOp, ex_memWrite, ex_ALUSrc, ex_regWrite};
                check("load_use_stall", 256'(load_use_stall), 256'(e.lus));
                check("ex_valid", 256'(a.valid), 256'(e.ex.valid));
                check("ex_ctrl", 256'({a.branch, a.memRead, a.memToReg, a.aluop,
                      a.memWrite, a.aluSrc, a.regWrite}),
                      256'({e.ex.branch, e.ex.memRead, e.ex.memToReg, e.ex.aluop,
                      e.ex.memWrite, e.ex.aluSrc, e.ex.regWrite}));
                check("ex_data", 256'({a.pc, a.rs1d, a.rs2d, a.imm}),
                      256'({e.ex.pc, e.ex.rs1d, e.ex.rs2d, e.ex.imm}));
                check("ex_fields", 256'({a.rs1, a.rs2, a.rd, a.f3, a.f75}),
                      256'({e.ex.rs1, e.ex.rs2, e.ex.rd, e.ex.f3, e.ex.f75}));
                check("bubble_count", 256'(bubble_count), 256'(e.cnt));
            end
        end
    end

    initial begin : driver
        instr_t i;
        int     wait_cycles;
        m_ex = '0; m_bubbles = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; id = rand_instr();
        @(posedge clk);
        #2;
        // Reset with random ID traffic
        step(mk(1, 0, 0, rand_instr()));
        step(mk(1, $urandom_range(1), $urandom_range(1), rand_instr()));
        // R-type pass-through
        i = rtype(5, 1, 2); i.rs1d = 32'h11; i.rs2d = 32'h22;
        step(mk(0, 0, 0, i));
        // lw x6 then add x7,x6,x1: one bubble, then the add proceeds
        step(mk(0, 0, 0, lw(6, 3)));
        step(mk(0, 0, 0, rtype(7, 6, 1)));
        step(mk(0, 0, 0, rtype(7, 6, 1)));
        // Load to x0 never stalls
        step(mk(0, 0, 0, lw(0, 3)));
        step(mk(0, 0, 0, rtype(8, 0, 0)));
        // I-type consumer whose rs2 field matches the load rd
        step(mk(0, 0, 0, lw(9, 3)));
        i = rtype(10, 4, 9); i.aluSrc = 1'b1;
        step(mk(0, 0, 0, i));
        // Hazard held under stall, then flush overrides stall and hazard
        step(mk(0, 0, 0, lw(11, 3)));
        step(mk(0, 1, 0, rtype(12, 11, 11)));
        step(mk(0, 1, 1, rtype(12, 11, 11)));
        // Frozen for three stall cycles
        step(mk(0, 0, 0, rtype(13, 1, 2)));
        for (int k = 0; k < 3; k++) step(mk(0, 1, 0, rand_instr()));
        // Drive the counter to saturation
        for (int k = 0; k < 20; k++) begin
            step(mk(0, 0, 0, lw(6, 3)));
            step(mk(0, 0, 0, rtype(7, 6, 1)));
            step(mk(0, 0, 0, rtype(7, 6, 1)));
        end
        // Randomized traffic, including the occasional reset
        for (int k = 0; k < 400; k++) begin
            step(mk($urandom_range(60) == 0, $urandom_range(5) == 0,
                    $urandom_range(7) == 0, rand_instr()));
        end
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the ID-stage decoder and the EX stage.
- Latches the decoded control bundle (branch, memRead, memToReg, ALUOp, memWrite, ALUSrc, regWrite) with the operand, immediate and PC data.
- Detects load-use hazards against the instruction currently in EX, inserts a bubble, and tells IF/ID to hold.
- Supports external stall and branch flush, and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate
- REG_W, 5, register-index width
- CNT_W, 16, width of the bubble performance counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  external hold (e.g. data-memory busy); freezes the whole register
- flush  in  1  branch/jump redirect; kills the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_W  register indices
- id_funct3  in  3  funct3 field
- id_funct7_5  in  1  instruction bit 30
- id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite  in  1 each  decoder outputs
- id_ALUOp  in  2  decoder ALUOp
- ex_*  out  same widths as the id_* inputs (except id_rs1_data/id_rs2_data)  registered copies
- ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
- ex_valid  out  1  registered valid
- load_use_stall  out  1  combinational; IF/ID and the PC must hold this cycle
- bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset:
  - Every ex_* output is 0, ex_valid=0 and bubble_count=0.
  - load_use_stall is forced to 0 while rst=1.
- Hazard term, combinational: hz = id_valid & ex_valid & ex_memRead & (ex_rd!=0) & ((id_rs1==ex_rd) | (use_rs2 & id_rs2==ex_rd)).
  - use_rs2 = ~id_ALUSrc | id_memWrite.
  - rs1 is always compared; this is conservative for J-type.
- load_use_stall = hz & ~flush & ~rst. A flush overrides the hazard because the ID instruction is dead.
- Per-edge priority, highest first:
  1. rst: clear everything.
  2. flush: load a bubble.
  3. stall: hold all ex_* and ex_valid unchanged. flush still wins when both are high.
  4. hz: load a bubble and increment bubble_count.
  5. Otherwise: load all id_* fields and set ex_valid=id_valid.
- Bubble definition:
  - ex_valid=0.
  - ex_branch, ex_memRead, ex_memToReg, ex_memWrite and ex_regWrite are 0, and ex_ALUOp=00.
  - ex_ALUSrc and all data/index fields (pc, operands, imm, rs1/rs2/rd, funct fields) still load from ID, so the outputs stay deterministic for the bench.
- An invalid ID instruction (id_valid=0) is loaded with its control bits forced to 0, the same as a bubble, but bubble_count does not increment.
- bubble_count:
  - Increments only on hazard bubbles, not on flushes or stalls.
  - Saturates at all-ones with no wrap.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble because ex_memRead clears the next cycle.
- A hazard under stall: load_use_stall stays asserted and no bubble is counted until stall drops.

Decomposition:
- Shared package (pipeline_pkg):
  - ALUOp encodings: ALUOP_ARITH, ALUOP_LDST, ALUOP_BRANCH, ALUOP_JMP.
  - A struct/typedef for the control bundle and a BUBBLE_CTRL constant.
  - Opcode constants shared with the decoder.
- One sub-module, hazard_detect: purely combinational, producing hz from the ID indices/valid and the EX rd/memRead/valid.

Test Plan:
- Reset: assert rst for 2 cycles with random id_* inputs -> all ex_* are 0, ex_valid=0, bubble_count=0, load_use_stall=0.
- Pass-through: id_valid=1, R-type (regWrite=1, ALUOp=arith, rd=5, rs1_data=0x11, rs2_data=0x22), no stall/flush -> next cycle ex_rd=5, ex_regWrite=1, operands 0x11/0x22, ex_valid=1.
- Load-use, first case: lw x6 in EX (ex_memRead=1, ex_rd=6) and add x7,x6,x1 in ID -> load_use_stall=1 the same cycle; next edge ex_valid=0 with control bits 0; bubble_count=1.
- Load-use, following cycle: the add then loads with load_use_stall=0.
- Load-use false cases: ex_rd=0, or an I-type ID instruction whose rs2 field equals ex_rd -> no stall and no bubble.
- Flush vs hazard vs stall: flush=1 together with hz=1 and stall=1 -> load_use_stall=0; next edge loads a bubble and bubble_count is unchanged. stall=1 alone for 3 cycles -> ex_* are frozen for those cycles.
- Saturation: preload by running 2^CNT_W hazards with a reduced CNT_W=4 -> bubble_count stays at 0xF.
